// File: rtl/cdma_dc_fifo_128x6.sv
// 128x6 valid/ready tag FIFO: registered write stage, 128-entry RAM, read prefetch plus output register.
// Build option CDMA_DC_FIFO_CLK_GATE_EN: state flops only advance while the gate condition is active.
module cdma_dc_fifo_128x6 (
   input  logic        clk,
   input  logic        reset_,
   input  logic        wr_req,
   output logic        wr_ready,
   input  logic [5:0]  wr_data,
   output logic        rd_req,
   input  logic        rd_ready,
   output logic [5:0]  rd_data,
   input  logic [31:0] pwrbus_ram_pd
);

   logic [5:0] ram [0:127];

   logic       in_vld_reg, in_vld_next;
   logic [5:0] in_data_reg;
   logic [6:0] wr_adr_reg;
   logic [7:0] wr_count_reg, wr_count_next;
   logic       wr_ready_reg, wr_ready_next;
   logic       wr_pop_reg;
   logic       rd_push_reg;
   logic [7:0] rd_count_reg, rd_count_next;
   logic [6:0] rd_adr_reg, ram_ra;
   logic       pf_vld_reg;
   logic [5:0] pf_data_reg;
   logic       rd_req_reg, rd_req_next;
   logic [5:0] rd_data_reg;

   logic wr_accept, wr_reserving, ram_we;
   logic out_pop, rd_popping, rd_enable, state_en;

   // Write side: the input register drains into RAM whenever RAM still has room.
   assign wr_accept     = wr_req && wr_ready_reg;
   assign wr_reserving  = in_vld_reg && (wr_count_reg != 8'd128);
   assign ram_we        = !reset_ && (wr_reserving || (1'b0 && (|pwrbus_ram_pd)));
   assign wr_count_next = wr_count_reg + {7'd0, wr_reserving} - {7'd0, wr_pop_reg};
   assign in_vld_next   = wr_accept || (in_vld_reg && !wr_reserving);
   // Stop accepting only when the captured word would be stuck behind a full RAM.
   assign wr_ready_next = !(in_vld_next && (wr_count_next == 8'd128));

   // Read side: prefetch slot refills from RAM whenever it is empty or being moved out.
   assign out_pop       = rd_req_reg && rd_ready;
   assign rd_popping    = pf_vld_reg && !(rd_req_reg && !rd_ready);
   assign rd_count_next = rd_count_reg + {7'd0, rd_push_reg} - {7'd0, rd_popping};
   assign rd_enable     = (rd_count_next != 8'd0) && (!pf_vld_reg || rd_popping);
   assign ram_ra        = rd_popping ? (rd_adr_reg + 7'd1) : rd_adr_reg;
   assign rd_req_next   = pf_vld_reg || (rd_req_reg && !rd_ready);

`ifdef CDMA_DC_FIFO_CLK_GATE_EN
   // Gated clock modelled as a flop enable; every state change falls inside this condition.
   assign state_en = wr_accept || wr_reserving || rd_push_reg || rd_popping || wr_pop_reg ||
                     in_vld_reg || (wr_ready_next != wr_ready_reg) || out_pop || reset_;
`else
   assign state_en = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset_) begin
         in_vld_reg   <= 1'b0;
         in_data_reg  <= 6'd0;
         wr_adr_reg   <= 7'd0;
         wr_count_reg <= 8'd0;
         wr_ready_reg <= 1'b1;
         wr_pop_reg   <= 1'b0;
         rd_push_reg  <= 1'b0;
         rd_count_reg <= 8'd0;
         rd_adr_reg   <= 7'd0;
         pf_vld_reg   <= 1'b0;
         rd_req_reg   <= 1'b0;
         rd_data_reg  <= 6'd0;
      end else if (state_en) begin
         in_vld_reg   <= in_vld_next;
         if (wr_accept)
            in_data_reg <= wr_data;
         if (wr_reserving)
            wr_adr_reg <= wr_adr_reg + 7'd1;
         wr_count_reg <= wr_count_next;
         wr_ready_reg <= wr_ready_next;
         wr_pop_reg   <= out_pop;
         rd_push_reg  <= wr_reserving;
         rd_count_reg <= rd_count_next;
         if (rd_popping)
            rd_adr_reg <= rd_adr_reg + 7'd1;
         pf_vld_reg   <= (rd_count_next != 8'd0);
         rd_req_reg   <= rd_req_next;
         if (rd_popping)
            rd_data_reg <= pf_data_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we)
         ram[wr_adr_reg] <= in_data_reg;
   end

   always_ff @(posedge clk) begin
      if (rd_enable && !reset_)
         pf_data_reg <= ram[ram_ra];
   end

   assign wr_ready = wr_ready_reg;
   assign rd_req   = rd_req_reg;
   assign rd_data  = rd_data_reg;

endmodule

// File: tb/tb_cdma_dc_fifo_128x6.sv
// Directed bench for cdma_dc_fifo_128x6: vector table for reset/single word, then
// hand sequences for full, streaming wrap, stall hold and mid-operation reset.
module tb_cdma_dc_fifo_128x6;

   logic        clk = 1'b0;
   logic        reset_;
   logic        wr_req;
   logic        wr_ready;
   logic [5:0]  wr_data;
   logic        rd_req;
   logic        rd_ready;
   logic [5:0]  rd_data;
   logic [31:0] pwrbus_ram_pd;

   always #5 clk = ~clk;

   cdma_dc_fifo_128x6 dut (
      .clk           (clk),
      .reset_        (reset_),
      .wr_req        (wr_req),
      .wr_ready      (wr_ready),
      .wr_data       (wr_data),
      .rd_req        (rd_req),
      .rd_ready      (rd_ready),
      .rd_data       (rd_data),
      .pwrbus_ram_pd (pwrbus_ram_pd)
   );

   typedef struct {
      logic       rst;
      logic       wreq;
      logic [5:0] wdata;
      logic       rrdy;
      logic       chk;
      logic       exp_wrdy;
      logic       exp_rreq;
      logic       chk_data;
      logic [5:0] exp_rdata;
   } vec_t;

   vec_t       vecs [9];
   logic [5:0] exp_q [$];
   int         n_checks = 0;
   int         n_fail = 0;

   function automatic vec_t mk(input logic rst, input logic wreq, input logic [5:0] wdata,
                               input logic rrdy, input logic chk, input logic exp_wrdy,
                               input logic exp_rreq, input logic chk_data,
                               input logic [5:0] exp_rdata);
      vec_t v;
      v.rst = rst; v.wreq = wreq; v.wdata = wdata; v.rrdy = rrdy; v.chk = chk;
      v.exp_wrdy = exp_wrdy; v.exp_rreq = exp_rreq; v.chk_data = chk_data;
      v.exp_rdata = exp_rdata;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic check_word(input string name);
      logic [5:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got %0h expected nothing (queue empty)", name, rd_data);
      end else begin
         e = exp_q.pop_front();
         $display("%s: read %0h expected %0h", name, rd_data, e);
         check(name, {26'd0, rd_data}, {26'd0, e});
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv, got, sent, first_rd, last_rd;
      logic       prev_stall;
      logic [5:0] prev_data;

      pwrbus_ram_pd = 32'd0;
      reset_   = 1'b1;
      wr_req   = 1'b0;
      wr_data  = 6'd0;
      rd_ready = 1'b0;

      // reset for 3 cycles, then a single word 0x2A accepted in cycle 0 (row 3)
      vecs[0] = mk(1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00);
      vecs[1] = mk(1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h00);
      vecs[2] = mk(1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h00);
      vecs[3] = mk(1'b0, 1'b1, 6'h2A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h00);
      vecs[4] = mk(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h00);
      vecs[5] = mk(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h00);
      vecs[6] = mk(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h00);
      vecs[7] = mk(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'h2A);
      vecs[8] = mk(1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00);

      for (int i = 0; i < 9; i++) begin
         reset_   = vecs[i].rst;
         wr_req   = vecs[i].wreq;
         wr_data  = vecs[i].wdata;
         rd_ready = vecs[i].rrdy;
         if (vecs[i].chk) begin
            $display("vec %0d: wr_ready=%0b rd_req=%0b rd_data=%0h", i, wr_ready, rd_req, rd_data);
            check($sformatf("vec%0d_wr_ready", i), {31'd0, wr_ready}, {31'd0, vecs[i].exp_wrdy});
            check($sformatf("vec%0d_rd_req", i), {31'd0, rd_req}, {31'd0, vecs[i].exp_rreq});
            if (vecs[i].chk_data)
               check($sformatf("vec%0d_rd_data", i), {26'd0, rd_data}, {26'd0, vecs[i].exp_rdata});
         end
         step();
      end
      wr_req = 1'b0;
      step();

      // full: no reads, offer 0..130, exactly 129 must be taken
      rd_ready = 1'b0;
      nv = 0;
      for (int c = 0; c < 200; c++) begin
         wr_req  = (nv < 131);
         wr_data = 6'(nv);
         if (wr_req && wr_ready) begin
            exp_q.push_back(6'(nv));
            nv++;
         end
         step();
      end
      wr_req = 1'b0;
      $display("full: accepted %0d words, wr_ready=%0b", nv, wr_ready);
      check("full_accepted", nv, 129);
      check("full_wr_ready_low", {31'd0, wr_ready}, 32'd0);
      rd_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 400 && got < 129; c++) begin
         if (rd_req) begin
            check_word("full_rd");
            got++;
         end
         step();
      end
      check("full_read_count", got, 129);
      step();
      step();
      check("full_wr_ready_back", {31'd0, wr_ready}, 32'd1);
      check("full_empty", {31'd0, rd_req}, 32'd0);

      // streaming wrap: 300 values mod 64, one word per cycle after latency
      sent = 0; got = 0; first_rd = -1; last_rd = 0;
      rd_ready = 1'b1;
      for (int c = 0; c < 600 && got < 300; c++) begin
         wr_req  = (sent < 300);
         wr_data = 6'(sent % 64);
         if (wr_req && wr_ready) begin
            exp_q.push_back(wr_data);
            sent++;
         end
         if (rd_req && rd_ready) begin
            check_word("stream_rd");
            if (got == 0)
               first_rd = c;
            last_rd = c;
            got++;
         end
         step();
      end
      wr_req = 1'b0;
      check("stream_count", got, 300);
      check("stream_first_latency", first_rd, 4);
      check("stream_throughput", last_rd - first_rd, 299);

      // stall hold: random rd_ready, data must freeze while stalled
      sent = 0; got = 0; prev_stall = 1'b0; prev_data = 6'd0;
      for (int c = 0; c < 1000 && got < 40; c++) begin
         wr_req  = (sent < 40);
         wr_data = 6'((sent * 7 + 3) % 64);
         if (wr_req && wr_ready) begin
            exp_q.push_back(wr_data);
            sent++;
         end
         if (prev_stall) begin
            check("stall_rd_req_hold", {31'd0, rd_req}, 32'd1);
            check("stall_rd_data_hold", {26'd0, rd_data}, {26'd0, prev_data});
         end
         rd_ready = 1'($urandom_range(0, 1));
         if (rd_req && rd_ready) begin
            check_word("stall_rd");
            got++;
         end
         prev_stall = rd_req && !rd_ready;
         prev_data  = rd_data;
         step();
      end
      wr_req = 1'b0;
      check("stall_count", got, 40);
      rd_ready = 1'b1;
      for (int k = 0; k < 6; k++)
         step();
      check("stall_no_dup", {31'd0, rd_req}, 32'd0);
      check("stall_queue_empty", exp_q.size(), 0);

      // mid-operation reset with 50 words stored
      rd_ready = 1'b0;
      sent = 0;
      for (int c = 0; c < 200 && sent < 50; c++) begin
         wr_req  = 1'b1;
         wr_data = 6'(sent + 9);
         if (wr_ready)
            sent++;
         step();
      end
      wr_req = 1'b0;
      for (int k = 0; k < 5; k++)
         step();
      check("mid_stored_rd_req", {31'd0, rd_req}, 32'd1);
      reset_ = 1'b1;
      step();
      reset_ = 1'b0;
      $display("mid reset: rd_req=%0b wr_ready=%0b rd_data=%0h", rd_req, wr_ready, rd_data);
      check("mid_rst_rd_req", {31'd0, rd_req}, 32'd0);
      check("mid_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      check("mid_rst_rd_data", {26'd0, rd_data}, 32'd0);
      rd_ready = 1'b1;
      wr_req   = 1'b1;
      wr_data  = 6'h15;
      step();
      wr_req = 1'b0;
      for (int k = 1; k < 4; k++) begin
         check($sformatf("mid_cyc%0d_rd_req", k), {31'd0, rd_req}, 32'd0);
         step();
      end
      $display("mid reset: word out rd_req=%0b rd_data=%0h", rd_req, rd_data);
      check("mid_cyc4_rd_req", {31'd0, rd_req}, 32'd1);
      check("mid_cyc4_rd_data", {26'd0, rd_data}, 32'h15);
      step();
      check("mid_cyc5_rd_req", {31'd0, rd_req}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
